// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard for decode hazard stalls.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 32'sd1 << ADDR_W;
    localparam logic ZERO_EN = (ZERO_REG != 32'sd0);
    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] a);
        return ZERO_EN && (a == {ADDR_W{1'b0}});
    endfunction

    function automatic logic [ADDR_W:0] popCount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [DATA_W-1:0] regsR [DEPTH];
    logic [DEPTH-1:0]  busyR;
    logic [DEPTH-1:0]  busyNextS;
    logic [DEPTH-1:0]  clrMaskS;
    logic [DEPTH-1:0]  setMaskS;
    logic [ADDR_W:0]   busyCntR;
    logic              we0EffS;
    logic              we1EffS;
    logic              issueEffS;

    // Register 0 (when hardwired) swallows writes and issues entirely.
    assign we0EffS   = we0 && !isZeroAddr(wa0);
    assign we1EffS   = we1 && !isZeroAddr(wa1);
    assign issueEffS = issue_en && !isZeroAddr(issue_addr);

    // Next busy vector: writes retire producers, a new issue re-marks (set applied last).
    always_comb begin
        clrMaskS  = ({DEPTH{we0EffS}} & (ONE_HOT0 << wa0)) |
                    ({DEPTH{we1EffS}} & (ONE_HOT0 << wa1));
        setMaskS  = {DEPTH{issueEffS}} & (ONE_HOT0 << issue_addr);
        busyNextS = (busyR & ~clrMaskS) | setMaskS;
    end

    // Register storage; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regsR[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (we0EffS) begin
                regsR[wa0] <= wd0;
            end
            if (we1EffS) begin
                regsR[wa1] <= wd1;
            end
        end
    end

    // Scoreboard state and its population count, kept in step every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busyR    <= {DEPTH{1'b0}};
            busyCntR <= {(ADDR_W+1){1'b0}};
        end else begin
            busyR    <= busyNextS;
            busyCntR <= popCount(busyNextS);
        end
    end

    assign busy_cnt = busyCntR;

    for (genvar g = 0; g < NUM_RD; g++) begin : gRead
        logic [ADDR_W-1:0] addrS;
        logic [DATA_W-1:0] rawDataS;
        logic              rawBusyS;
        logic              forceZeroS;

        assign addrS = rd_addr[g*ADDR_W +: ADDR_W];

        // Read mux, with the optional forward of in-flight write data and busy state.
        always_comb begin
`ifdef REGFILE_BYPASS_EN
            if (we1EffS && (wa1 == addrS)) begin
                rawDataS = wd1;
            end else if (we0EffS && (wa0 == addrS)) begin
                rawDataS = wd0;
            end else begin
                rawDataS = regsR[addrS];
            end
            rawBusyS = busyNextS[addrS];
`else
            rawDataS = regsR[addrS];
            rawBusyS = busyR[addrS];
`endif
        end

        // Reset must blank reads immediately, even with a bypassed write pending.
        assign forceZeroS = !rst || isZeroAddr(addrS);
        assign rd_data[g*DATA_W +: DATA_W] = forceZeroS ? {DATA_W{1'b0}} : rawDataS;
        assign rd_busy[g] = forceZeroS ? 1'b0 : rawBusyS;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: reference model plus a queue of expected read results.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [AW:0]       busy_cnt;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_cnt(busy_cnt)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mRegs [32];
    logic [31:0] mBusy;
    int          nChecks = 0;
    int          nFail   = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mBusy = 32'd0;
    endtask

    // Model of one clock edge: port 1 applied after port 0, issue applied after clears.
    task automatic modelUpdate();
        if (we0 && wa0 != 5'd0) begin
            mRegs[wa0] = wd0;
            mBusy[wa0] = 1'b0;
        end
        if (we1 && wa1 != 5'd0) begin
            mRegs[wa1] = wd1;
            mBusy[wa1] = 1'b0;
        end
        if (issue_en && issue_addr != 5'd0) mBusy[issue_addr] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) modelUpdate();
        #1;
        checkVal("busy_cnt", 32'(busy_cnt), 32'($countones(mBusy)));
        @(negedge clk);
        we0 = 1'b0;
        we1 = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic drive(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic iss, input logic [4:0] ia);
        we0 = w0; wa0 = a0; wd0 = d0;
        we1 = w1; wa1 = a1; wd1 = d1;
        issue_en = iss; issue_addr = ia;
        step();
    endtask

    task automatic readPorts(input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        rd_addr = {a1, a0};
        e.port = 0; e.data = mRegs[a0]; e.busy = mBusy[a0]; expQ.push_back(e);
        e.port = 1; e.data = mRegs[a1]; e.busy = mBusy[a1]; expQ.push_back(e);
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal($sformatf("rd_data%0d", e.port), rd_data[e.port*DW +: DW], e.data);
            checkVal($sformatf("rd_busy%0d", e.port), 32'(rd_busy[e.port]), 32'(e.busy));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0;
        we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0;
        issue_en = 1'b0; issue_addr = 5'd0;
        rd_addr = '0;
        modelReset();
        #2;
        readPorts(5'd5, 5'd0);
        checkVal("busy_cnt_rst", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic write then read-back next cycle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        readPorts(5'd5, 5'd7);
`ifdef REGFILE_BYPASS_EN
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'hCAFEF00D;
        rd_addr = {5'd0, 5'd6};
        #1;
        checkVal("bypass_data", rd_data[31:0], 32'hCAFEF00D);
        step();
`endif

        // Dual write collision: port 1 wins.
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
        readPorts(5'd7, 5'd5);
        checkVal("reg7_p1_wins", rd_data[31:0], 32'h22);

        // Register 0 ignores writes and issues.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
        readPorts(5'd0, 5'd5);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        checkVal("busy_cnt_zero_issue", 32'(busy_cnt), 32'd0);

        // Scoreboard set / simultaneous set+clear / clear.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        readPorts(5'd3, 5'd3);
        drive(1'b1, 5'd3, 32'hAB, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        readPorts(5'd3, 5'd0);
        drive(1'b1, 5'd3, 32'hCD, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        readPorts(5'd3, 5'd3);
        checkVal("busy_cnt_cleared", 32'(busy_cnt), 32'd0);

        // Fill the scoreboard completely, then drain it two registers at a time.
        for (int k = 1; k < 32; k++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(k));
        end
        checkVal("busy_cnt_full", 32'(busy_cnt), 32'd31);
        readPorts(5'd31, 5'd1);
        for (int k = 1; k < 32; k += 2) begin
            drive(1'b1, 5'(k), 32'(k * 32'h01010101), (k < 31), 5'(k + 1), 32'(k + 32'h1000), 1'b0, 5'd0);
        end
        checkVal("busy_cnt_empty", 32'(busy_cnt), 32'd0);
        readPorts(5'd16, 5'd31);

        // Randomised traffic against the model.
        repeat (300) begin
            drive(1'($urandom_range(1)), 5'($urandom_range(31)), $urandom(),
                  1'($urandom_range(1)), 5'($urandom_range(31)), $urandom(),
                  1'($urandom_range(1)), 5'($urandom_range(31)));
            readPorts(5'($urandom_range(31)), 5'($urandom_range(31)));
        end

        // Mid-run asynchronous reset with a write in flight.
        drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        #1;
        rst = 1'b0;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
        modelReset();
        readPorts(5'd4, 5'd5);
        checkVal("busy_cnt_async_rst", 32'(busy_cnt), 32'd0);
        @(posedge clk);
        #1;
        checkVal("busy_cnt_in_rst", 32'(busy_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        we0 = 1'b0;
        readPorts(5'd9, 5'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
